// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
package alu_pkg;

  localparam int CTRL_W_DEF = 5;

  // Opcodes are compared after zero-extending ALUControl to 32 bits, which
  // keeps the decode independent of CTRL_W.
  localparam logic [31:0] ALU_ADD = 32'd1;
  localparam logic [31:0] ALU_SUB = 32'd2;
  localparam logic [31:0] ALU_MUL = 32'd3;
  localparam logic [31:0] ALU_SLL = 32'd4;
  localparam logic [31:0] ALU_SRL = 32'd5;
  localparam logic [31:0] ALU_AND = 32'd6;
  localparam logic [31:0] ALU_OR  = 32'd7;
  localparam logic [31:0] ALU_XOR = 32'd8;
  localparam logic [31:0] ALU_SRA = 32'd9;
  localparam logic [31:0] ALU_LTU = 32'd10;
  localparam logic [31:0] ALU_GE  = 32'd11;
  localparam logic [31:0] ALU_EQ  = 32'd12;
  localparam logic [31:0] ALU_NOR = 32'd13;
  localparam logic [31:0] ALU_LT  = 32'd14;
  localparam logic [31:0] ALU_NE  = 32'd15;
  localparam logic [31:0] ALU_GT  = 32'd16;
  localparam logic [31:0] ALU_LE  = 32'd17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// full 2*WIDTH product, done pulses one cycle after the last bit.
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [2*WIDTH-1:0] acc_p1;
  logic [SHW-1:0]     cnt;
  logic               busy;

  // Operand capture: pure data, loaded only on start.
  always_ff @(posedge Clk) begin
    if (start) begin
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      mplier_p0 <= b;
    end
  end

  // Control and accumulator: one partial product per cycle while busy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc_p1 <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        acc_p1 <= '0;
      end else if (busy) begin
        if (mplier_p0[cnt]) begin
          acc_p1 <= acc_p1 + (mcand_p0 << cnt);
        end
        cnt <= cnt + 1'b1;
        if (cnt == SHW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = acc_p1;

endmodule

// File: rtl/alu_mc_pipe.sv
// EX-stage ALU with valid/ready on both sides: single-cycle ops register
// on the accept edge, MUL hands off to the iterative multiplier.
module alu_mc_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SHW    = $clog2(WIDTH),
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  ALUResult,
  output logic [WIDTH-1:0]  ResultHi,
  output logic              Zero,
  output logic              Overflow
);

  state_t               state;
  state_t               state_nxt;
  logic [31:0]          op;
  logic                 accept;
  logic                 is_mul;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]     sum_p0;
  logic [WIDTH-1:0]     diff_p0;
  logic [WIDTH-1:0]     res_p0;
  logic                 ovf_p0;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // SUB overflows when operand signs differ and the result flips from A.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign op      = 32'(ALUControl);
  assign is_mul  = (op == ALU_MUL);
  assign InReady = (state == ST_IDLE) && (!OutValid || OutReady);
  assign accept  = InValid && InReady;
  assign a_s     = A;
  assign b_s     = B;
  assign sum_p0  = A + B;
  assign diff_p0 = A - B;

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .Clk   (Clk),
    .Reset (Reset),
    .start (accept && is_mul),
    .a     (A),
    .b     (B),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle result and overflow, decoded from the current opcode.
  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    case (op)
      ALU_ADD: begin
        res_p0 = sum_p0;
        ovf_p0 = add_ovf(A, B, sum_p0);
      end
      ALU_SUB: begin
        res_p0 = diff_p0;
        ovf_p0 = sub_ovf(A, B, diff_p0);
      end
      ALU_SLL: res_p0 = A << B[SHW-1:0];
      ALU_SRL: res_p0 = A >> B[SHW-1:0];
      ALU_SRA: res_p0 = $unsigned(a_s >>> B[SHW-1:0]);
      ALU_AND: res_p0 = A & B;
      ALU_OR:  res_p0 = A | B;
      ALU_XOR: res_p0 = A ^ B;
      ALU_NOR: res_p0 = ~(A | B);
      ALU_LTU: res_p0 = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_GE:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s >= b_s)};
      ALU_EQ:  res_p0 = {{(WIDTH-1){1'b0}}, (A == B)};
      ALU_LT:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_NE:  res_p0 = {{(WIDTH-1){1'b0}}, (A != B)};
      ALU_GT:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s > b_s)};
      ALU_LE:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s <= b_s)};
      default: res_p0 = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: MUL is entered on its accept and left when the product lands.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)         state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output registers: load on a single-cycle accept or on multiplier done,
  // otherwise hold until the consumer takes the result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid  <= 1'b0;
      ALUResult <= '0;
      ResultHi  <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
    end else if (state == ST_MUL) begin
      if (mul_done) begin
        OutValid  <= 1'b1;
        ALUResult <= mul_prod[WIDTH-1:0];
        ResultHi  <= mul_prod[2*WIDTH-1:WIDTH];
        Zero      <= (mul_prod[WIDTH-1:0] == '0);
        Overflow  <= 1'b0;
      end
    end else if (accept) begin
      if (is_mul) begin
        OutValid <= 1'b0;
      end else begin
        OutValid  <= 1'b1;
        ALUResult <= res_p0;
        ResultHi  <= '0;
        Zero      <= (res_p0 == '0);
        Overflow  <= ovf_p0;
      end
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule
